// File: rtl/spi_slave_reg.sv
// spi_slave_reg: SPI slave (CPOL=1, CPHA=1) that decodes frames into register
// file strobes. Everything runs on clk_sys, which oversamples the SPI pins.
//   clk_sys, rst_n           : system clock, async active-low reset
//   spi_csn/sck/mosi/miso    : SPI pins (miso is driven, never tristated)
//   reg_addr/wr/wdata        : write address, one-cycle write strobe, data
//   reg_rd/rdata             : one-cycle read strobe, data RD_LAT cycles later
//   spi_busy                 : synchronised ~csn
// Frame: command byte {rw, addr[6:0]}, then data bytes with auto-increment.
module spi_slave_reg #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RD_LAT      = 1
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       spi_csn,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [6:0] reg_addr,
  output logic       reg_wr,
  output logic [7:0] reg_wdata,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       spi_busy
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] csn_q, sck_q, mosi_q, vld_q;
  logic                   csn_s, sck_s, mosi_s;
  logic                   sck_d, csn_d;
  logic                   rise, fall, csn_fall, byte_done;
  logic [7:0]             byte_in;

  logic [2:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [7:0]        tx;
  logic              rw;
  logic              first_fall;
  logic              inc_pend;
  logic [RD_LAT-1:0] rd_pipe;

  assign csn_s  = csn_q[SYNC_STAGES-1];
  assign sck_s  = sck_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // csn/sck chains reset to their idle-high level so reset itself never looks
  // like an edge. csn_d only tracks csn once the chain holds real post-reset
  // samples, so a csn already low at reset release is not taken as a frame start.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      csn_q  <= '1;
      sck_q  <= '1;
      mosi_q <= '0;
      vld_q  <= '0;
      sck_d  <= 1'b1;
      csn_d  <= 1'b0;
    end else begin
      csn_q  <= {csn_q[SYNC_STAGES-2:0], spi_csn};
      sck_q  <= {sck_q[SYNC_STAGES-2:0], spi_sck};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
      vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      sck_d  <= sck_s;
      csn_d  <= vld_q[SYNC_STAGES-1] & csn_s;
    end
  end

  assign rise      = sck_s & ~sck_d;
  assign fall      = ~sck_s & sck_d;
  assign csn_fall  = csn_d & ~csn_s;
  assign byte_done = rise && (bit_cnt == 3'd7) && (state != IDLE);
  assign byte_in   = {shreg[6:0], mosi_s};

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (csn_fall) state_nxt = CMD;
      CMD: begin
        if (csn_s)          state_nxt = IDLE;
        else if (byte_done) state_nxt = DATA;
      end
      DATA: if (csn_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A rise is still processed in the cycle csn is seen high, so a byte whose
  // 8th rise coincides with csn release completes and issues its strobe.
  // Writes increment the address one cycle after the strobe; reads increment
  // together with the next prefetch strobe.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      reg_addr   <= '0;
      reg_wr     <= 1'b0;
      reg_wdata  <= '0;
      reg_rd     <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx         <= '0;
      rw         <= 1'b0;
      first_fall <= 1'b0;
      inc_pend   <= 1'b0;
      rd_pipe    <= '0;
    end else begin
      reg_wr   <= 1'b0;
      reg_rd   <= 1'b0;
      inc_pend <= 1'b0;
      rd_pipe  <= (rd_pipe << 1) | RD_LAT'(reg_rd);
      if (inc_pend) reg_addr <= reg_addr + 7'd1;

      if (state == IDLE) begin
        bit_cnt    <= '0;
        shreg      <= '0;
        tx         <= '0;
        first_fall <= 1'b0;
      end else begin
        if (rise) begin
          shreg   <= byte_in;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (byte_done) begin
          first_fall <= 1'b0;
          if (state == CMD) begin
            rw       <= byte_in[7];
            reg_addr <= byte_in[6:0];
            reg_rd   <= byte_in[7];
          end else if (!rw) begin
            reg_wr    <= 1'b1;
            reg_wdata <= byte_in;
            inc_pend  <= 1'b1;
          end else begin
            reg_addr <= reg_addr + 7'd1;
            reg_rd   <= 1'b1;
          end
        end
        // First fall of a byte presents the MSB already in tx[7].
        if ((state == DATA) && rw && fall) begin
          if (first_fall) tx <= {tx[6:0], 1'b0};
          first_fall <= 1'b1;
        end
        if (rd_pipe[RD_LAT-1]) tx <= reg_rdata;
      end
    end
  end

  assign spi_miso = ((state == DATA) && rw) ? tx[7] : 1'b0;
  assign spi_busy = ~csn_s;

endmodule

// File: tb/tb_spi_slave_reg.sv
// Directed testbench for spi_slave_reg: 100 MHz clk_sys, 10 MHz SPI master
// sending 8 bits then 2 idle bit-times per byte.
module tb_spi_slave_reg;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       spi_csn, spi_sck, spi_mosi, spi_miso;
  logic [6:0] reg_addr;
  logic       reg_wr, reg_rd, spi_busy;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata = 8'h00;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [6:0] wr_addr [0:31];
  logic [7:0] wr_data [0:31];
  logic [6:0] rd_addr [0:31];
  int wr_n = 0;
  int rd_n = 0;

  spi_slave_reg #(.SYNC_STAGES(2), .RD_LAT(1)) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .spi_csn  (spi_csn),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .reg_addr (reg_addr),
    .reg_wr   (reg_wr),
    .reg_wdata(reg_wdata),
    .reg_rd   (reg_rd),
    .reg_rdata(reg_rdata),
    .spi_busy (spi_busy)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] mem_val(input logic [6:0] a);
    case (a)
      7'h00:   mem_val = 8'hA1;
      7'h01:   mem_val = 8'hB2;
      7'h02:   mem_val = 8'hC3;
      7'h03:   mem_val = 8'h3C;
      default: mem_val = {1'b0, a} ^ 8'h5A;
    endcase
  endfunction

  // Register file read port, one cycle latency.
  always @(posedge clk_sys) if (reg_rd) reg_rdata <= mem_val(reg_addr);

  // Strobe logger, sampled on the falling edge.
  always @(negedge clk_sys) begin
    if (rst_n === 1'b1) begin
      if (reg_wr === 1'b1 && wr_n < 32) begin
        wr_addr[wr_n] = reg_addr;
        wr_data[wr_n] = reg_wdata;
        wr_n = wr_n + 1;
      end
      if (reg_rd === 1'b1 && rd_n < 32) begin
        rd_addr[rd_n] = reg_addr;
        rd_n = rd_n + 1;
      end
    end
  end

  // Master: drive on fall, sample miso just before rise; nbits MSB first.
  task automatic spi_xfer(input logic [7:0] txb, input int nbits, output logic [7:0] rxb);
    rxb = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_sck  = 1'b0;
      spi_mosi = txb[7-i];
      #50;
      rxb = {rxb[6:0], spi_miso};
      spi_sck = 1'b1;
      #50;
    end
  endtask

  task automatic spi_byte(input logic [7:0] txb, output logic [7:0] rxb);
    spi_xfer(txb, 8, rxb);
    #200;
  endtask

  task automatic frame_start;
    @(negedge clk_sys);
    spi_csn = 1'b0;
    #100;
  endtask

  task automatic frame_end;
    spi_csn = 1'b1;
    #300;
  endtask

  task automatic test_reset;
    if ({spi_miso, reg_wr, reg_rd, spi_busy} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_strobes: got %b want 0000", {spi_miso, reg_wr, reg_rd, spi_busy});
    end
    tests_run++;
    if (reg_addr !== 7'h00) begin
      tests_failed++;
      $display("FAIL reset_addr: got %h want 00", reg_addr);
    end
    tests_run++;
    if (reg_wdata !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_wdata: got %h want 00", reg_wdata);
    end
    tests_run++;
  endtask

  task automatic test_write;
    int w0, r0;
    logic [7:0] rx;
    w0 = wr_n; r0 = rd_n;
    frame_start();
    if (spi_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL write_busy: got %b want 1", spi_busy);
    end
    tests_run++;
    spi_byte(8'h05, rx);
    spi_byte(8'hA5, rx);
    frame_end();
    if (wr_n - w0 !== 1) begin
      tests_failed++;
      $display("FAIL write_count: got %0d want 1", wr_n - w0);
    end
    tests_run++;
    if ({wr_addr[w0], wr_data[w0]} !== {7'h05, 8'hA5}) begin
      tests_failed++;
      $display("FAIL write_addr_data: got %h/%h want 05/a5", wr_addr[w0], wr_data[w0]);
    end
    tests_run++;
    if (rd_n - r0 !== 0) begin
      tests_failed++;
      $display("FAIL write_no_rd: got %0d want 0", rd_n - r0);
    end
    tests_run++;
    if (spi_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_busy_end: got %b want 0", spi_busy);
    end
    tests_run++;
  endtask

  task automatic test_read;
    int r0;
    logic [7:0] rx;
    r0 = rd_n;
    frame_start();
    spi_byte(8'h83, rx);
    spi_byte(8'h00, rx);
    frame_end();
    if (rx !== 8'h3C) begin
      tests_failed++;
      $display("FAIL read_miso: got %h want 3c", rx);
    end
    tests_run++;
    // Command strobe at 03 plus the prefetch strobe at 04 after the data byte.
    if (rd_n - r0 !== 2) begin
      tests_failed++;
      $display("FAIL read_count: got %0d want 2", rd_n - r0);
    end
    tests_run++;
    if ({rd_addr[r0], rd_addr[r0+1]} !== {7'h03, 7'h04}) begin
      tests_failed++;
      $display("FAIL read_addr: got %h,%h want 03,04", rd_addr[r0], rd_addr[r0+1]);
    end
    tests_run++;
  endtask

  task automatic test_burst_wrap;
    int w0;
    logic [7:0] rx;
    w0 = wr_n;
    frame_start();
    spi_byte(8'h7F, rx);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    frame_end();
    if (wr_n - w0 !== 2) begin
      tests_failed++;
      $display("FAIL wrap_count: got %0d want 2", wr_n - w0);
    end
    tests_run++;
    if ({wr_addr[w0], wr_data[w0]} !== {7'h7F, 8'h11}) begin
      tests_failed++;
      $display("FAIL wrap_first: got %h/%h want 7f/11", wr_addr[w0], wr_data[w0]);
    end
    tests_run++;
    if ({wr_addr[w0+1], wr_data[w0+1]} !== {7'h00, 8'h22}) begin
      tests_failed++;
      $display("FAIL wrap_second: got %h/%h want 00/22", wr_addr[w0+1], wr_data[w0+1]);
    end
    tests_run++;
  endtask

  task automatic test_abort;
    int w0;
    logic [7:0] rx;
    w0 = wr_n;
    frame_start();
    spi_byte(8'h05, rx);
    spi_xfer(8'hFF, 5, rx);
    #100;
    frame_end();
    if (wr_n - w0 !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_wr: got %0d want 0", wr_n - w0);
    end
    tests_run++;
    if (reg_addr !== 7'h05) begin
      tests_failed++;
      $display("FAIL abort_addr_hold: got %h want 05", reg_addr);
    end
    tests_run++;
    frame_start();
    spi_byte(8'h06, rx);
    spi_byte(8'h5A, rx);
    frame_end();
    if (wr_n - w0 !== 1 || {wr_addr[w0], wr_data[w0]} !== {7'h06, 8'h5A}) begin
      tests_failed++;
      $display("FAIL abort_next_frame: got n=%0d %h/%h want n=1 06/5a",
               wr_n - w0, wr_addr[w0], wr_data[w0]);
    end
    tests_run++;
  endtask

  task automatic test_back_to_back;
    int r0;
    logic [7:0] rx0, rx1, rx;
    r0 = rd_n;
    frame_start();
    spi_byte(8'h80, rx);
    spi_byte(8'h00, rx0);
    spi_byte(8'h00, rx1);
    frame_end();
    if (rd_n - r0 !== 3) begin
      tests_failed++;
      $display("FAIL burst_rd_count: got %0d want 3", rd_n - r0);
    end
    tests_run++;
    if ({rd_addr[r0], rd_addr[r0+1], rd_addr[r0+2]} !== {7'h00, 7'h01, 7'h02}) begin
      tests_failed++;
      $display("FAIL burst_rd_addr: got %h,%h,%h want 00,01,02",
               rd_addr[r0], rd_addr[r0+1], rd_addr[r0+2]);
    end
    tests_run++;
    if ({rx0, rx1} !== {8'hA1, 8'hB2}) begin
      tests_failed++;
      $display("FAIL burst_rd_miso: got %h,%h want a1,b2", rx0, rx1);
    end
    tests_run++;
  endtask

  task automatic test_reset_mid_read;
    int w0, r0;
    logic [7:0] rx;
    frame_start();
    spi_byte(8'h83, rx);
    spi_xfer(8'h00, 3, rx);   // third bit of 0x3C is 1
    #20;
    if (spi_miso !== 1'b1) begin
      tests_failed++;
      $display("FAIL midread_miso_pre: got %b want 1", spi_miso);
    end
    tests_run++;
    rst_n = 1'b0;
    #1;
    if ({spi_miso, reg_rd, reg_wr, spi_busy} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midread_reset_outputs: got %b want 0000",
               {spi_miso, reg_rd, reg_wr, spi_busy});
    end
    tests_run++;
    #39;
    @(negedge clk_sys);
    rst_n = 1'b1;
    w0 = wr_n; r0 = rd_n;
    // Master carries on with csn still low; nothing may be decoded.
    #100;
    spi_xfer(8'h00, 5, rx);
    #200;
    spi_byte(8'h01, rx);
    spi_byte(8'h77, rx);
    frame_end();
    if ((wr_n - w0) + (rd_n - r0) !== 0) begin
      tests_failed++;
      $display("FAIL midread_no_decode: got %0d strobes want 0", (wr_n - w0) + (rd_n - r0));
    end
    tests_run++;
    r0 = rd_n;
    frame_start();
    spi_byte(8'h83, rx);
    spi_byte(8'h00, rx);
    frame_end();
    if (rd_n - r0 < 1 || rd_addr[r0] !== 7'h03 || rx !== 8'h3C) begin
      tests_failed++;
      $display("FAIL midread_recover: got n=%0d addr=%h miso=%h want addr=03 miso=3c",
               rd_n - r0, rd_addr[r0], rx);
    end
    tests_run++;
  endtask

  initial begin
    rst_n    = 1'b0;
    spi_csn  = 1'b1;
    spi_sck  = 1'b1;
    spi_mosi = 1'b0;
    #33;
    test_reset();
    @(negedge clk_sys);
    rst_n = 1'b1;
    #100;
    test_write();
    test_read();
    test_burst_wrap();
    test_abort();
    test_back_to_back();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
